// File: rtl/consmax_pkg.sv
// Shared constants and types for the ConSmax LUT programming path.
package consmax_pkg;

   localparam int CONSMAX_LUT_DATA  = 16;
   localparam int CONSMAX_LUT_ADDR  = 4;
   localparam int CONSMAX_DRAIN_CYC = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } consmax_ldr_state_e;

endpackage

// File: rtl/consmax_lut_loader.sv
// LUT programming master: turns a valid/ready stream of BF16 entries into
// registered lut_waddr/lut_wen/lut_wdata writes, with busy/done/aborted status.
module consmax_lut_loader
   import consmax_pkg::*;
#(
   parameter int LUT_DATA = CONSMAX_LUT_DATA,
   parameter int LUT_ADDR = CONSMAX_LUT_ADDR
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                cfg_start,
   input  logic [LUT_ADDR:0]   cfg_base_addr,
   input  logic [LUT_ADDR:0]   cfg_len,
   input  logic                cfg_abort,
   input  logic [LUT_DATA-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [LUT_ADDR:0]   lut_waddr,
   output logic                lut_wen,
   output logic [LUT_DATA-1:0] lut_wdata,
   output logic                busy,
   output logic                done,
   output logic                aborted
);

   localparam int AW = LUT_ADDR + 1;
   localparam int CW = LUT_ADDR + 2;
   // A length of zero encodes the full two-LUT table.
   localparam logic [CW-1:0] FULL_CNT   = {1'b1, {AW{1'b0}}};
   localparam logic [1:0]    DRAIN_LAST = 2'(CONSMAX_DRAIN_CYC - 1);

   consmax_ldr_state_e  state_q, state_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [CW-1:0]       rem_q, rem_d;
   logic [1:0]          drain_q, drain_d;
   logic                in_ready_q, in_ready_d;
   logic [AW-1:0]       lut_waddr_q, lut_waddr_d;
   logic                lut_wen_q, lut_wen_d;
   logic [LUT_DATA-1:0] lut_wdata_q, lut_wdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                beat;

   // Next-state, counters and registered output values.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      drain_d     = drain_q;
      lut_waddr_d = lut_waddr_q;
      lut_wdata_d = lut_wdata_q;
      lut_wen_d   = 1'b0;
      done_d      = 1'b0;
      aborted_d   = aborted_q;
      // Abort wins over a same-edge beat, so that beat is neither written nor consumed.
      beat        = (state_q == LOAD) && in_valid && in_ready_q && !cfg_abort;

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d   = LOAD;
               addr_d    = cfg_base_addr;
               rem_d     = (cfg_len == '0) ? FULL_CNT : {1'b0, cfg_len};
               aborted_d = 1'b0;
            end
         end
         LOAD: begin
            if (cfg_abort) begin
               aborted_d = 1'b1;
               state_d   = DRAIN;
               drain_d   = '0;
            end else if (beat) begin
               lut_wen_d   = 1'b1;
               lut_waddr_d = addr_q;
               lut_wdata_d = in_data;
               addr_d      = addr_q + 1'b1;   // wraps from the top of LUT1 to LUT0
               rem_d       = rem_q - 1'b1;
               if (rem_q == CW'(1)) begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end
         end
         DRAIN: begin
            // Hold off long enough for the consumer's input stage and SRAM write edge.
            if (drain_q == DRAIN_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == LOAD);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers; all return to idle values on reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         drain_q     <= '0;
         in_ready_q  <= 1'b0;
         lut_waddr_q <= '0;
         lut_wen_q   <= 1'b0;
         lut_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         drain_q     <= drain_d;
         in_ready_q  <= in_ready_d;
         lut_waddr_q <= lut_waddr_d;
         lut_wen_q   <= lut_wen_d;
         lut_wdata_q <= lut_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign lut_waddr = lut_waddr_q;
   assign lut_wen   = lut_wen_q;
   assign lut_wdata = lut_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = aborted_q;

endmodule

// File: tb/tb_consmax_lut_loader.sv
// Scoreboard bench for consmax_lut_loader: the driver predicts every LUT write
// from the load parameters and queues it; a monitor pops and compares writes.
module tb_consmax_lut_loader;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        cfg_start = 1'b0;
   logic [4:0]  cfg_base_addr = '0;
   logic [4:0]  cfg_len = '0;
   logic        cfg_abort = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  lut_waddr;
   logic        lut_wen;
   logic [15:0] lut_wdata;
   logic        busy;
   logic        done;
   logic        aborted;

   consmax_lut_loader dut (
      .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
      .cfg_len(cfg_len), .cfg_abort(cfg_abort), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .lut_waddr(lut_waddr), .lut_wen(lut_wen), .lut_wdata(lut_wdata),
      .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  addr;
      logic [15:0] data;
   } wr_t;

   wr_t wq[$];
   int  checks = 0;
   int  failures = 0;
   int  edge_no = 0;

   always @(posedge clk) edge_no <= edge_no + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest predicted write.
   always @(negedge clk) begin
      if (rstn && lut_wen) begin
         if (wq.size() == 0) begin
            chk("unexpected_write", {27'd0, lut_waddr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = wq.pop_front();
            chk("waddr", {27'd0, lut_waddr}, {27'd0, e.addr});
            chk("wdata", {16'd0, lut_wdata}, {16'd0, e.data});
         end
      end
   end

   // One load: base/len, optional abort at beat number, optional ignored start,
   // valid either from a fixed per-cycle pattern, random, or always high.
   task automatic run_load(input int base, input int len, input int abort_beat,
                           input int ign_beat, input bit use_pat, input logic [31:0] vpat,
                           input bit rand_valid, input bit seq_data);
      int n, i, addr, step, last_edge, exp_done_edge;
      bit ab, seen;
      n = (len == 0) ? 32 : len;
      i = 0; addr = base; step = 0; ab = 1'b0; last_edge = 0;
      @(negedge clk);
      cfg_start = 1'b1; cfg_base_addr = 5'(base); cfg_len = 5'(len);
      @(posedge clk); #1;
      cfg_start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("ready_after_start", {31'd0, in_ready}, 32'd1);
      while (i < n && step < 300) begin
         bit v, a;
         logic [15:0] d;
         @(negedge clk);
         chk("ready_in_load", {31'd0, in_ready}, 32'd1);
         if (use_pat) v = (step < 32) ? vpat[step] : 1'b1;
         else if (rand_valid) v = 1'($urandom_range(0, 1));
         else v = 1'b1;
         a = (abort_beat == i + 1);
         if (a) v = 1'b1;
         d = seq_data ? 16'(16'h3F80 + i) : 16'($urandom);
         in_valid = v; in_data = d; cfg_abort = a;
         cfg_start = (ign_beat == i + 1);
         if (ign_beat == i + 1) begin cfg_base_addr = 5'd10; cfg_len = 5'd2; end
         @(posedge clk); #1;
         step++;
         if (a) begin ab = 1'b1; last_edge = edge_no; break; end
         if (v) begin
            wq.push_back('{addr: 5'(addr), data: d});
            addr = (addr + 1) % 32;
            i++;
            last_edge = edge_no;
         end
      end
      in_valid = 1'b0; cfg_abort = 1'b0; cfg_start = 1'b0;
      if (step >= 300) chk("load_progress", 32'(i), 32'(n));
      exp_done_edge = last_edge + 2;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
         chk("busy_in_drain", {31'd0, busy}, 32'd1);
         chk("ready_in_drain", {31'd0, in_ready}, 32'd0);
      end
      chk("done_seen", {31'd0, seen}, 32'd1);
      chk("done_edge", 32'(edge_no), 32'(exp_done_edge));
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("aborted", {31'd0, aborted}, {31'd0, ab});
      chk("pending_writes", 32'(wq.size()), 32'd0);
      @(negedge clk);
      chk("done_pulse_one_cycle", {31'd0, done}, 32'd0);
      chk("aborted_sticky", {31'd0, aborted}, {31'd0, ab});
   endtask

   initial begin
      #12;
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_wen", {31'd0, lut_wen}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_aborted", {31'd0, aborted}, 32'd0);
      chk("rst_waddr", {27'd0, lut_waddr}, 32'd0);
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Full table, back-to-back.
      run_load(0, 0, 0, 0, 1'b0, 32'd0, 1'b0, 1'b1);
      // Address wrap from the top of LUT1 into LUT0.
      run_load(30, 4, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
      // Fixed bubble pattern 1,0,0,1,0,1.
      run_load(7, 3, 0, 0, 1'b1, 32'b101001, 1'b0, 1'b0);
      // Start pulsed during LOAD must be ignored.
      run_load(3, 5, 0, 2, 1'b0, 32'd0, 1'b0, 1'b0);
      // Abort on the same edge as beat 6 of 8.
      run_load(12, 8, 6, 0, 1'b0, 32'd0, 1'b0, 1'b0);
      // Next start clears the sticky aborted flag.
      run_load(20, 2, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);
      // Random loads with random bubbles and occasional aborts.
      for (int r = 0; r < 6; r++) begin
         int ab_at;
         ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), ab_at, 0,
                  1'b0, 32'd0, 1'b1, 1'b0);
      end

      // Reset in the middle of a load after three writes.
      @(negedge clk);
      cfg_start = 1'b1; cfg_base_addr = 5'd0; cfg_len = 5'd8;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 16'hBEE0 + 16'(b);
         @(posedge clk); #1;
         wq.push_back('{addr: 5'(b), data: 16'hBEE0 + 16'(b)});
      end
      in_valid = 1'b0;
      @(negedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_wen", {31'd0, lut_wen}, 32'd0);
      chk("mid_rst_waddr", {27'd0, lut_waddr}, 32'd0);
      chk("mid_rst_wdata", {16'd0, lut_wdata}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_pending", 32'(wq.size()), 32'd0);
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
      run_load(5, 1, 0, 0, 1'b0, 32'd0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
